// File: rtl/onchip_mem_stream_reader.sv
// Read-side DMA stage: streams a contiguous word range out of the on-chip RAM
// as a sop/eop-framed valid/ready packet through a 3-entry skid FIFO.
module onchip_mem_stream_reader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5120,
    parameter int LEN_W  = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sop,
    output logic                out_eop
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(DEPTH);

    state_t              r_state, w_state_nxt;
    logic                r_busy, r_done, r_error;
    logic [ADDR_W-1:0]   r_addr, r_mem_addr;
    logic [LEN_W-1:0]    r_issue_rem, r_pop_rem;
    logic                r_mem_cs, r_cs_sop, r_cs_eop;
    logic                r_pend, r_pend_sop, r_pend_eop;
    logic [DATA_W-1:0]   r_fifo_data [0:2];
    logic                r_fifo_sop  [0:2];
    logic                r_fifo_eop  [0:2];
    logic [1:0]          r_rd, r_wr, r_count;

    logic                w_pop, w_cmd_bad, w_accept, w_reject;
    logic                w_run_issue, w_last_pop;
    logic [2:0]          w_used;
    logic [LEN_W:0]      w_end;

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign mem_address    = r_mem_addr;
    assign mem_chipselect = r_mem_cs;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifo_data[r_rd];
    assign out_sop   = out_valid & r_fifo_sop[r_rd];
    assign out_eop   = out_valid & r_fifo_eop[r_rd];

    // Slots in use counts the two-stage RAM pipeline (request, returning data)
    // plus the FIFO, minus this cycle's pop, so a full-rate stream never bubbles.
    always_comb begin
        w_pop       = out_valid & out_ready;
        w_end       = (LEN_W+1)'(base_addr) + {1'b0, length};
        w_cmd_bad   = (length == '0) || (w_end > DEPTH_L);
        w_accept    = (r_state == S_IDLE) && start && !w_cmd_bad;
        w_reject    = (r_state == S_IDLE) && start && w_cmd_bad;
        w_used      = 3'(r_count) + 3'(r_mem_cs) + 3'(r_pend) - 3'(w_pop);
        w_run_issue = (r_state == S_RUN) && (r_issue_rem != '0) && (w_used < 3'd3);
        w_last_pop  = (r_state == S_RUN) && w_pop && (r_pop_rem == LEN_W'(1));
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_RUN;
            S_RUN:   if (w_last_pop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_issue_rem <= '0;
            r_pop_rem   <= '0;
            r_mem_cs    <= 1'b0;
            r_cs_sop    <= 1'b0;
            r_cs_eop    <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_sop  <= 1'b0;
            r_pend_eop  <= 1'b0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_sop[i]  <= 1'b0;
                r_fifo_eop[i]  <= 1'b0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= w_last_pop;
            r_error  <= w_reject;
            r_mem_cs <= w_accept | w_run_issue;
            if (w_accept)
                r_busy <= 1'b1;
            else if (w_last_pop)
                r_busy <= 1'b0;

            // The first read goes out on the accept edge itself.
            if (w_accept) begin
                r_mem_addr  <= base_addr;
                r_addr      <= base_addr + ADDR_W'(1);
                r_issue_rem <= length - LEN_W'(1);
                r_pop_rem   <= length;
                r_cs_sop    <= 1'b1;
                r_cs_eop    <= (length == LEN_W'(1));
            end else if (w_run_issue) begin
                r_mem_addr  <= r_addr;
                r_addr      <= r_addr + ADDR_W'(1);
                r_issue_rem <= r_issue_rem - LEN_W'(1);
                r_cs_sop    <= 1'b0;
                r_cs_eop    <= (r_issue_rem == LEN_W'(1));
            end

            r_pend     <= r_mem_cs;
            r_pend_sop <= r_cs_sop;
            r_pend_eop <= r_cs_eop;

            if (r_pend) begin
                r_fifo_data[r_wr] <= mem_readdata;
                r_fifo_sop[r_wr]  <= r_pend_sop;
                r_fifo_eop[r_wr]  <= r_pend_eop;
                r_wr              <= (r_wr == 2'd2) ? 2'd0 : r_wr + 2'd1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == 2'd2) ? 2'd0 : r_rd + 2'd1;
                if (r_pop_rem != '0)
                    r_pop_rem <= r_pop_rem - LEN_W'(1);
            end
            r_count <= r_count + 2'(r_pend) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader with a registered-read RAM model.
module tb_onchip_mem_stream_reader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 5120;
    localparam int LEN_W  = 14;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              sop;
        logic              eop;
    } word_t;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [LEN_W-1:0]    length;
    logic                busy, done, error;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect, mem_clken, mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic [DATA_W-1:0]   mem_readdata;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid, out_ready, out_sop, out_eop;

    logic [DATA_W-1:0]   ram [0:DEPTH-1];
    word_t               sb[$];
    word_t               prev_word, exp_w;
    logic                prev_stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cs_cnt = 0, pop_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, oob_cnt = 0;
    int rdy_mode = 0, rdy_target = 0;

    onchip_mem_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .error(error),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_clken(mem_clken), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken && !mem_write) begin
            if (int'(mem_address) < DEPTH) mem_readdata <= ram[mem_address];
            else oob_cnt++;
        end
    end

    // out_ready generator: 0 always 1, 1 pattern 1,0,0,1, 2 always 0, 3 ready until target pops
    initial begin
        int phase;
        phase = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin out_ready = (phase == 0) || (phase == 3); phase = (phase + 1) % 4; end
                2: out_ready = 1'b0;
                3: out_ready = (pop_cnt < rdy_target);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            pop_cnt    = cs_cnt;
        end else begin
            if (mem_chipselect) cs_cnt++;
            if (error) err_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            check("outstanding_le3", 64'((cs_cnt - pop_cnt) <= 3), 64'd1);
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'({out_data, out_sop, out_eop}), 64'(prev_word));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'hDEAD);
                end else begin
                    exp_w = sb.pop_front();
                    check("data", 64'(out_data), 64'(exp_w.d));
                    check("sop",  64'(out_sop),  64'(exp_w.sop));
                    check("eop",  64'(out_eop),  64'(exp_w.eop));
                end
                pop_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_data, out_sop, out_eop};
        end
    end

    task automatic send(input int b, input int l, input bit ok);
        word_t w;
        @(negedge clk);
        base_addr = ADDR_W'(b);
        length    = LEN_W'(l);
        start     = 1'b1;
        if (ok) begin
            for (int j = 0; j < l; j++) begin
                w.d   = 32'hA000_0000 + 32'(b + j);
                w.sop = (j == 0);
                w.eop = (j == l - 1);
                sb.push_back(w);
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_timeout"}, 64'(k < 300), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_sopeop"}, 64'({out_sop, out_eop}), 64'd0);
        check({tag, "_cs"},    64'(mem_chipselect), 64'd0);
    endtask

    initial begin
        int d0, c0, e0, b0, k;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'hA000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_addr", 64'(mem_address), 64'd0);
        reset_n = 1'b1;

        // Full-rate transfer: latency 2 and no bubbles
        d0 = done_cnt; c0 = cs_cnt;
        send(16, 8, 1'b1);
        @(negedge clk);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_lat0", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("t1_nobubble", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        wait_done(d0, "t1");
        check("t1_reads", 64'(cs_cnt - c0), 64'd8);

        // Same transfer with backpressure pattern
        rdy_mode = 1;
        d0 = done_cnt; c0 = cs_cnt;
        send(16, 8, 1'b1);
        wait_done(d0, "t2");
        check("t2_reads", 64'(cs_cnt - c0), 64'd8);
        rdy_mode = 0;

        // Last RAM word, then an out-of-range command
        d0 = done_cnt;
        send(5119, 1, 1'b1);
        wait_done(d0, "t3");
        e0 = err_cnt; c0 = cs_cnt; b0 = busy_cnt;
        send(5119, 2, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_err_pulse", 64'(err_cnt - e0), 64'd1);
        check("t3_no_cs", 64'(cs_cnt - c0), 64'd0);
        check("t3_no_busy", 64'(busy_cnt - b0), 64'd0);

        // Zero length
        e0 = err_cnt; c0 = cs_cnt; b0 = busy_cnt;
        send(40, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_err_pulse", 64'(err_cnt - e0), 64'd1);
        check("t4_no_cs", 64'(cs_cnt - c0), 64'd0);
        check("t4_no_busy", 64'(busy_cnt - b0), 64'd0);

        // Start while busy is ignored
        d0 = done_cnt; c0 = cs_cnt; e0 = err_cnt;
        send(40, 5, 1'b1);
        send(200, 3, 1'b0);
        check("t5_still_busy", 64'(busy), 64'd1);
        wait_done(d0, "t5");
        check("t5_reads", 64'(cs_cnt - c0), 64'd5);
        check("t5_no_err", 64'(err_cnt - e0), 64'd0);

        // Reset after three of ten words accepted
        rdy_target = pop_cnt + 3;
        rdy_mode = 3;
        @(negedge clk);
        d0 = done_cnt;
        send(100, 10, 1'b1);
        k = 0;
        while (pop_cnt < rdy_target && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_three_popped", 64'(k < 100), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("t6_rst");
        reset_n = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_valid_low", 64'(out_valid), 64'd0);
        d0 = done_cnt;
        send(0, 4, 1'b1);
        wait_done(d0, "t6");

        // Long stall: reads stop at three outstanding
        rdy_mode = 2;
        @(negedge clk);
        d0 = done_cnt; c0 = cs_cnt;
        send(300, 10, 1'b1);
        repeat (20) @(negedge clk);
        check("t7_reads_stalled", 64'(cs_cnt - c0), 64'd3);
        check("t7_valid_held", 64'(out_valid), 64'd1);
        rdy_mode = 0;
        wait_done(d0, "t7");
        check("t7_reads", 64'(cs_cnt - c0), 64'd10);

        check("ram_in_range", 64'(oob_cnt), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/onchip_mem_stream_reader.md
Name: onchip_mem_stream_reader

Overview:
Read-side DMA stage that sits directly downstream of the 5120x32 single-port on-chip RAM. On a start command it reads a contiguous word range from the RAM over its native port (address/chipselect/clken/write/byteenable, 1-cycle read latency). It emits the words as a packetised valid/ready stream with sop/eop. An internal 3-entry skid FIFO absorbs the RAM latency, sustains 1 word/cycle, and has no combinational path from out_ready to the RAM port.

Parameters:
ADDR_W, 13, RAM word-address width
DATA_W, 32, RAM/stream data width
DEPTH, 5120, RAM depth in words; upper bound for range check
LEN_W, 14, length field width (must hold DEPTH)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
start  in  1  command strobe; sampled only in IDLE
base_addr  in  ADDR_W  first word address, sampled with start
length  in  LEN_W  word count, sampled with start
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse after last word is accepted downstream
error  out  1  1-cycle pulse on rejected command
mem_address  out  ADDR_W  RAM word address
mem_chipselect  out  1  read-issue qualifier; high exactly on cycles a read is issued
mem_clken  out  1  RAM clock enable; tied 1
mem_write  out  1  tied 0
mem_byteenable  out  DATA_W/8  tied all-ones
mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after issue
out_data  out  DATA_W  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_sop  out  1  first word of packet; qualified by out_valid
out_eop  out  1  last word of packet; qualified by out_valid

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; busy, done, error, out_valid, out_sop, out_eop, mem_chipselect = 0; mem_address=0; FIFO emptied; in-flight flag cleared; counters zeroed. Mid-packet reset abandons the packet with no eop and no done.
- Command check in IDLE when start=1:
  - length==0 or base_addr+length > DEPTH (LEN_W+1-bit compare): error=1 next cycle, stay IDLE, no RAM access.
  - Otherwise: latch addr=base_addr, issue_rem=length, pop_rem=length; busy=1 next cycle; go RUN.
  - start while busy is ignored. No address wrap-around is possible.
- RUN issue rule (registered outputs): issue a read when issue_rem>0 and (fifo_count + inflight) < 3.
  - On issue: mem_chipselect=1, mem_address=addr; then addr+1, issue_rem-1, inflight=1.
  - inflight clears the following cycle, when mem_readdata is pushed into the FIFO.
- FIFO: 3 entries, each holding {data, sop, eop}.
  - sop is tagged on the word whose issue had issue_rem==length; eop on the word whose issue had issue_rem==1. A 1-word packet carries both.
  - out_valid = FIFO not empty; out_data/sop/eop come from the head entry.
  - Pop when out_valid & out_ready. Push and pop in the same cycle are allowed.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready held 1, the first out_valid appears 2 cycles after the start edge, followed by one word per cycle with no bubbles.
- Completion: when the eop word pops (pop_rem 1->0), the next cycle has done=1 and busy=0, and the FSM returns to IDLE. A new start is accepted in the same cycle done is high.
- FSM states: IDLE -> RUN on a valid start; RUN -> IDLE on the eop pop; any state -> IDLE on reset.
- Counters are unsigned. issue_rem and pop_rem never underflow; issue stops at 0.

Test Plan:
- Preload RAM[i]=0xA000_0000+i. start with base=16, length=8, out_ready=1 -> 8 words 0xA0000010..0xA0000017 on consecutive cycles, sop on first, eop on last, done pulses once, busy falls with done.
- Same transfer with out_ready toggled 1,0,0,1 repeating -> identical data order, no drops or duplicates, outputs held stable while stalled, never more than 3 reads outstanding+buffered.
- base=5119, length=1 -> single word with sop=eop=1, done; then base=5119, length=2 -> error pulse, no mem_chipselect, busy stays 0.
- length=0 -> error pulse only. Also assert start during RUN with different args -> ignored, original packet completes unchanged.
- Assert reset_n=0 for 1 cycle after 3 of 10 words are accepted -> all outputs 0 next cycle, FIFO empty, no done; a fresh start base=0, length=4 then completes normally.
- out_ready=0 for 20 cycles after start with length=10 -> exactly 3 reads issued, then mem_chipselect stays 0 until space frees.
